writeback_scoreboard: RTL and testbench
=======================================

Name: writeback_scoreboard

Overview:
Writeback and hazard-tracking stage for the four-slot VLIW datapath. Slot order is 0=LSU, 1=IXU1, 2=IXU2, 3=BRANCH.
- Tracks a busy bit per architectural register and stalls issue of bundles with RAW/WAW hazards.
- Registers functional-unit results and drives the register file's four write ports with one cycle of latency.
- Resolves same-destination collisions so that at most one write port targets a given register per cycle.

Parameters:
NUM_REGS, 32, architectural register count; r0 is hardwired zero.
REG_W, 5, register index width (log2 NUM_REGS).
DATA_W, 32, register data width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
issue_valid  in  1  decoded bundle presented for issue.
issue_rd_en  in  4  per-slot destination-write enable.
issue_rd  in  4*REG_W  per-slot destination; slot i at bits [i*REG_W +: REG_W].
issue_rs_en  in  8  source-read enables; entry 2i = slot i rs1, entry 2i+1 = slot i rs2.
issue_rs  in  8*REG_W  source indices, packed as issue_rs_en.
issue_stall  out  1  bundle is not accepted this cycle.
result_valid  in  4  per-slot result available this cycle.
result_rd  in  4*REG_W  per-slot result destination.
result_data  in  4*DATA_W  per-slot result data.
rf_wr_en  out  4  register-file write enables, slot order.
rf_wr_rd  out  4*REG_W  register-file write destinations.
rf_wr_data  out  4*DATA_W  register-file write data.
busy  out  NUM_REGS  scoreboard state; bit 0 always 0.
pending_cnt  out  REG_W+1  popcount of busy.
dup_wr_err  out  1  one-cycle pulse: two or more result slots with the same nonzero rd.
spurious_wr_err  out  1  one-cycle pulse: a result targeted a non-busy register.

Behaviour:
Reset:
- All regs clear: busy=0, rf_wr_en=0, rf_wr_rd=0, rf_wr_data=0, dup_wr_err=0, spurious_wr_err=0.
- Asserting rst mid-operation drops staged writes and clears all busy bits at that edge.

Issue (combinational):
- issue_stall=1 iff issue_valid and either:
  - any enabled source has a nonzero index with busy set, or
  - any enabled destination has a nonzero index with busy set.
- Hazard check reads the registered busy vector only. A register cleared at the coming edge still stalls this cycle, giving one conservative bubble.
- issue_stall=0 whenever issue_valid=0.

Issue accept and busy set:
- Accept = issue_valid && !issue_stall.
- On accept, busy[rd] is set at the edge for each enabled slot with rd != 0.
- Duplicate rd within one accepted bundle sets the bit once; the register clears after its first writeback.

Result staging (1-cycle latency):
- For each slot i, at the edge: rf_wr_en[i] <= result_valid[i] && rd_i != 0 && no higher-index slj>i has a valid result with the same rd.
- rf_wr_rd and rf_wr_data for slot i always capture that slot's inputs.
- Priority: BRANCH > IXU2 > IXU1 > LSU. Losing slots are suppressed and dup_wr_err pulses for that cycle.
- Results to r0 never assert rf_wr_en.

Busy clear:
- At the edge ending a cycle with rf_wr_en[i]=1, busy[rf_wr_rd[i]] clears.
- This is the same edge at which the register file captures the data, so the cycle after the clear reads the new value.

Simultaneous set and clear of the same register at one edge: set wins.

spurious_wr_err:
- Pulses one cycle after a staged write whose rd was not busy in the cycle it was staged.
- The write still proceeds.

pending_cnt is the combinational popcount of busy. Its maximum is NUM_REGS-1.

Test Plan:
- Reset, then issue slot1 rd=5 and slot0 rd=7: busy[5]=busy[7]=1, pending_cnt=2, issue_stall=0.
- With busy[5]=1, present a bundle with slot2 rs1=5 → issue_stall=1. Then result_valid[1] rd=5 data=0xDEADBEEF → next cycle rf_wr_en[1]=1, rf_wr_rd slot1=5, data 0xDEADBEEF. busy[5] clears at the end of that cycle; issue_stall drops the following cycle.
- Issue rd=9 on slot0 and slot3; both results arrive in the same cycle with data 0x11 / 0x22 → rf_wr_en=4'b1000, slot3 data 0x22, dup_wr_err=1 for one cycle, busy[9]=0 afterward.
- result_valid[2] rd=0 data=0xFFFFFFFF → rf_wr_en[2]=0, busy[0]=0, no error pulse.
- result_valid[0] rd=12 with busy[12]=0 → rf_wr_en[0]=1 next cycle, spurious_wr_err=1 for one cycle.
- Three pending registers plus a staged write, then assert rst for one cycle → busy=0, pending_cnt=0, rf_wr_en=0 the next cycle. An issue immediately after is accepted with no stall.

Source files
------------

// File: rtl/writeback_scoreboard.sv
// -----------------------------------------------------------------------------
// writeback_scoreboard
//
// Writeback and hazard-tracking stage for the four-slot VLIW datapath.
// Slot order: 0=LSU, 1=IXU1, 2=IXU2, 3=BRANCH.
//
// Holds one busy bit per architectural register. A bundle that reads or
// writes a busy register is stalled. Functional-unit results are registered
// and drive the register file write ports one cycle later. When several
// slots target the same register in one cycle, only the highest-index slot
// writes.
//
// Handshake: the issue side has no separate ready signal. A bundle is
// accepted in any cycle where issue_valid=1 and issue_stall=0; the producer
// must hold the bundle stable while issue_stall=1. Results are fire-and-forget:
// result_valid[i] is sampled every cycle and is never back-pressured.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   issue_valid     bundle presented for issue
//   issue_rd_en/rd  per-slot destination enable / index
//   issue_rs_en/rs  source enables / indices (2i = slot i rs1, 2i+1 = rs2)
//   issue_stall     bundle not accepted this cycle
//   result_valid/rd/data  per-slot results from the functional units
//   rf_wr_en/rd/data      registered register-file write ports
//   busy            scoreboard state (bit 0 always 0)
//   pending_cnt     number of busy registers
//   dup_wr_err      pulse: two or more results hit the same nonzero rd
//   spurious_wr_err pulse: a staged write targeted a non-busy register
// -----------------------------------------------------------------------------
module writeback_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [3:0]            issue_rd_en,
  input  logic [4*REG_W-1:0]    issue_rd,
  input  logic [7:0]            issue_rs_en,
  input  logic [8*REG_W-1:0]    issue_rs,
  output logic                  issue_stall,
  input  logic [3:0]            result_valid,
  input  logic [4*REG_W-1:0]    result_rd,
  input  logic [4*DATA_W-1:0]   result_data,
  output logic [3:0]            rf_wr_en,
  output logic [4*REG_W-1:0]    rf_wr_rd,
  output logic [4*DATA_W-1:0]   rf_wr_data,
  output logic [NUM_REGS-1:0]   busy,
  output logic [REG_W:0]        pending_cnt,
  output logic                  dup_wr_err,
  output logic                  spurious_wr_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [3:0]          rf_wr_en_q, rf_wr_en_d;
  logic [4*REG_W-1:0]  rf_wr_rd_q, rf_wr_rd_d;
  logic [4*DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                dup_wr_err_q, dup_wr_err_d;
  logic                spurious_wr_err_q, spurious_wr_err_d;

  logic                hazard;
  logic                accept;
  logic [REG_W:0]      pending_cnt_d;

  // Hazard check uses only the registered busy vector. A register being
  // cleared at the coming edge still stalls this cycle (one bubble).
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (issue_rs_en[j] && (issue_rs[j*REG_W +: REG_W] != '0) &&
          busy_q[issue_rs[j*REG_W +: REG_W]])
        hazard = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (issue_rd_en[i] && (issue_rd[i*REG_W +: REG_W] != '0) &&
          busy_q[issue_rd[i*REG_W +: REG_W]])
        hazard = 1'b1;
    end
    issue_stall = issue_valid && hazard;
    accept      = issue_valid && !hazard;
  end

  // Result staging: a slot writes unless a higher-index slot has a valid
  // result for the same register in the same cycle.
  always_comb begin
    rf_wr_en_d        = '0;
    rf_wr_rd_d        = result_rd;
    rf_wr_data_d      = result_data;
    dup_wr_err_d      = 1'b0;
    spurious_wr_err_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rf_wr_en_d[i] = result_valid[i] && (result_rd[i*REG_W +: REG_W] != '0);
      for (int j = i + 1; j < 4; j++) begin
        if (result_valid[i] && result_valid[j] &&
            (result_rd[i*REG_W +: REG_W] != '0) &&
            (result_rd[i*REG_W +: REG_W] == result_rd[j*REG_W +: REG_W])) begin
          rf_wr_en_d[i] = 1'b0;
          dup_wr_err_d  = 1'b1;
        end
      end
      if (rf_wr_en_d[i] && !busy_q[result_rd[i*REG_W +: REG_W]])
        spurious_wr_err_d = 1'b1;
    end
  end

  // Busy update: clears from the write ports first, then sets from the
  // accepted bundle so that a simultaneous set wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < 4; i++) begin
      if (rf_wr_en_q[i])
        busy_d[rf_wr_rd_q[i*REG_W +: REG_W]] = 1'b0;
    end
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (issue_rd_en[i] && (issue_rd[i*REG_W +: REG_W] != '0))
          busy_d[issue_rd[i*REG_W +: REG_W]] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      pending_cnt_d = pending_cnt_d + (REG_W+1)'(busy_q[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q            <= '0;
      rf_wr_en_q        <= '0;
      rf_wr_rd_q        <= '0;
      rf_wr_data_q      <= '0;
      dup_wr_err_q      <= 1'b0;
      spurious_wr_err_q <= 1'b0;
    end else begin
      busy_q            <= busy_d;
      rf_wr_en_q        <= rf_wr_en_d;
      rf_wr_rd_q        <= rf_wr_rd_d;
      rf_wr_data_q      <= rf_wr_data_d;
      dup_wr_err_q      <= dup_wr_err_d;
      spurious_wr_err_q <= spurious_wr_err_d;
    end
  end

  assign busy            = busy_q;
  assign pending_cnt     = pending_cnt_d;
  assign rf_wr_en        = rf_wr_en_q;
  assign rf_wr_rd        = rf_wr_rd_q;
  assign rf_wr_data      = rf_wr_data_q;
  assign dup_wr_err      = dup_wr_err_q;
  assign spurious_wr_err = spurious_wr_err_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
module tb_writeback_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;

  logic                  clk;
  logic                  rst;
  logic                  issue_valid;
  logic [3:0]            issue_rd_en;
  logic [4*REG_W-1:0]    issue_rd;
  logic [7:0]            issue_rs_en;
  logic [8*REG_W-1:0]    issue_rs;
  logic                  issue_stall;
  logic [3:0]            result_valid;
  logic [4*REG_W-1:0]    result_rd;
  logic [4*DATA_W-1:0]   result_data;
  logic [3:0]            rf_wr_en;
  logic [4*REG_W-1:0]    rf_wr_rd;
  logic [4*DATA_W-1:0]   rf_wr_data;
  logic [NUM_REGS-1:0]   busy;
  logic [REG_W:0]        pending_cnt;
  logic                  dup_wr_err;
  logic                  spurious_wr_err;

  int total;
  int bad;

  writeback_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .issue_rs_en(issue_rs_en), .issue_rs(issue_rs), .issue_stall(issue_stall),
    .result_valid(result_valid), .result_rd(result_rd), .result_data(result_data),
    .rf_wr_en(rf_wr_en), .rf_wr_rd(rf_wr_rd), .rf_wr_data(rf_wr_data),
    .busy(busy), .pending_cnt(pending_cnt),
    .dup_wr_err(dup_wr_err), .spurious_wr_err(spurious_wr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_rd_en  = '0;
    issue_rd     = '0;
    issue_rs_en  = '0;
    issue_rs     = '0;
    result_valid = '0;
    result_rd    = '0;
    result_data  = '0;
  endtask

  // advance one clock; inputs and checks happen 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_slot(input int slot, input logic [REG_W-1:0] rd);
    issue_valid = 1'b1;
    issue_rd_en[slot] = 1'b1;
    issue_rd[slot*REG_W +: REG_W] = rd;
  endtask

  task automatic result_slot(input int slot, input logic [REG_W-1:0] rd,
                             input logic [DATA_W-1:0] data);
    result_valid[slot] = 1'b1;
    result_rd[slot*REG_W +: REG_W] = rd;
    result_data[slot*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_wr_rd", rf_wr_rd, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_dup", dup_wr_err, 0);
    check("rst_spur", spurious_wr_err, 0);
    check("rst_stall", issue_stall, 0);

    // issue slot1 rd=5, slot0 rd=7
    step();
    issue_slot(1, 5);
    issue_slot(0, 7);
    settle();
    check("iss57_stall", issue_stall, 0);
    step();
    idle_inputs();
    settle();
    check("iss57_busy", busy, 32'h0000_00A0);
    check("iss57_pending", pending_cnt, 2);

    // RAW on r5 stalls; result for r5 arrives in the same cycle
    issue_valid = 1'b1;
    issue_rs_en[4] = 1'b1;
    issue_rs[4*REG_W +: REG_W] = 5;
    result_slot(1, 5, 32'hDEADBEEF);
    settle();
    check("raw_stall", issue_stall, 1);
    step();
    result_valid = '0;
    settle();
    check("raw_wr_en", rf_wr_en, 4'b0010);
    check("raw_wr_rd1", rf_wr_rd[1*REG_W +: REG_W], 5);
    check("raw_wr_data1", rf_wr_data[1*DATA_W +: DATA_W], 32'hDEADBEEF);
    check("raw_spur", spurious_wr_err, 0);
    check("raw_stall_bubble", issue_stall, 1);
    step();
    settle();
    check("raw_busy_clr", busy, 32'h0000_0080);
    check("raw_stall_drop", issue_stall, 0);
    step();
    idle_inputs();

    // WAW collision: rd=9 on slots 0 and 3
    issue_slot(0, 9);
    issue_slot(3, 9);
    settle();
    check("dup_iss_stall", issue_stall, 0);
    step();
    idle_inputs();
    settle();
    check("dup_busy", busy, 32'h0000_0280);
    check("dup_pending", pending_cnt, 2);
    result_slot(0, 9, 32'h11);
    result_slot(3, 9, 32'h22);
    step();
    idle_inputs();
    settle();
    check("dup_wr_en", rf_wr_en, 4'b1000);
    check("dup_wr_data3", rf_wr_data[3*DATA_W +: DATA_W], 32'h22);
    check("dup_err", dup_wr_err, 1);
    check("dup_spur", spurious_wr_err, 0);
    step();
    settle();
    check("dup_err_drop", dup_wr_err, 0);
    check("dup_busy_clr", busy, 32'h0000_0080);

    // write to r0 is dropped silently
    result_slot(2, 0, 32'hFFFFFFFF);
    step();
    idle_inputs();
    settle();
    check("r0_wr_en", rf_wr_en, 0);
    check("r0_busy0", busy[0], 0);
    check("r0_dup", dup_wr_err, 0);
    check("r0_spur", spurious_wr_err, 0);

    // spurious write to non-busy r12
    result_slot(0, 12, 32'h1234);
    step();
    idle_inputs();
    settle();
    check("spur_wr_en", rf_wr_en, 4'b0001);
    check("spur_wr_rd0", rf_wr_rd[0 +: REG_W], 12);
    check("spur_err", spurious_wr_err, 1);
    step();
    settle();
    check("spur_err_drop", spurious_wr_err, 0);
    check("spur_busy", busy, 32'h0000_0080);

    // set and clear of r3 at the same edge: set wins
    result_slot(1, 3, 32'h33);
    step();
    idle_inputs();
    issue_slot(2, 3);
    settle();
    check("setclr_wr_en", rf_wr_en, 4'b0010);
    check("setclr_stall", issue_stall, 0);
    step();
    idle_inputs();
    settle();
    check("setclr_busy", busy, 32'h0000_0088);
    check("setclr_pending", pending_cnt, 2);

    // WAW on busy r3 stalls
    issue_slot(0, 3);
    settle();
    check("waw_stall", issue_stall, 1);
    idle_inputs();

    // three pending plus a staged write, then reset
    issue_slot(2, 10);
    result_slot(0, 7, 32'h77);
    step();
    idle_inputs();
    settle();
    check("pre_rst_busy", busy, 32'h0000_0488);
    check("pre_rst_pending", pending_cnt, 3);
    check("pre_rst_wr_en", rf_wr_en, 4'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pending", pending_cnt, 0);
    check("mid_rst_wr_en", rf_wr_en, 0);
    issue_slot(0, 3);
    settle();
    check("post_rst_stall", issue_stall, 0);
    step();
    idle_inputs();
    settle();
    check("post_rst_busy", busy, 32'h0000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
